// File: rtl/viterbi_pkg.sv
// viterbi_pkg
// Shared helpers for the Viterbi decoder blocks (branch metric, ACS and
// survivor memory). Derives the state count and state width from the
// constraint length and defines the trellis predecessor function.
//
// Trellis convention: next state = {u, s[SW-1:1]}, so the input bit that
// led into state s is s[SW-1]. The two predecessors of s are
// {s[SW-2:0], 0} and {s[SW-2:0], 1}.
package viterbi_pkg;

    // Number of trellis states for constraint length k.
    function automatic int num_states(input int k);
        return 1 << (k - 1);
    endfunction

    // Width of a state index for constraint length k.
    function automatic int state_bits(input int k);
        return k - 1;
    endfunction

    // Predecessor of state s when the ACS decision for s is d.
    // The predecessor is {s[sw-2:0], d}.
    function automatic int pred_state(input int s, input logic d, input int sw);
        return ((s << 1) | int'(d)) & ((1 << sw) - 1);
    endfunction

endpackage

// File: rtl/min_metric_select.sv
// min_metric_select
// Combinational argmin tree over NUM_STATES unsigned path metrics. The
// tree has log2(NUM_STATES) levels. Where two metrics are equal, the lower
// state index wins.
//
// Ports:
//   pm        in   NUM_STATES*PM_W  packed metrics, state s at [s*PM_W +: PM_W]
//   best_idx  out  log2(NUM_STATES) index of the smallest metric
//   best_val  out  PM_W             value of the smallest metric
module min_metric_select #(
    parameter  int NUM_STATES = 4,
    parameter  int PM_W       = 2,
    localparam int IDX_W      = $clog2(NUM_STATES)
) (
    input  logic [NUM_STATES*PM_W-1:0] pm,
    output logic [IDX_W-1:0]           best_idx,
    output logic [PM_W-1:0]            best_val
);

    // Level 0 holds the raw metrics. Each higher level halves the candidate
    // count. Within every pair, the even (left) node always covers lower
    // state indices than the odd (right) node. The right node therefore
    // only wins when its metric is strictly smaller, which gives the
    // lowest-index tie-break.
    for (genvar lv = 0; lv <= IDX_W; lv++) begin : g_lvl
        localparam int CNT = NUM_STATES >> lv;

        logic [PM_W-1:0]  val [CNT];
        logic [IDX_W-1:0] idx [CNT];

        if (lv == 0) begin : g_leaf
            for (genvar n = 0; n < CNT; n++) begin : g_node
                assign val[n] = pm[n*PM_W +: PM_W];
                assign idx[n] = IDX_W'(n);
            end
        end else begin : g_merge
            for (genvar n = 0; n < CNT; n++) begin : g_node
                logic take_right;
                assign take_right = g_lvl[lv-1].val[2*n+1] < g_lvl[lv-1].val[2*n];
                assign val[n] = take_right ? g_lvl[lv-1].val[2*n+1] : g_lvl[lv-1].val[2*n];
                assign idx[n] = take_right ? g_lvl[lv-1].idx[2*n+1] : g_lvl[lv-1].idx[2*n];
            end
        end
    end

    assign best_idx = g_lvl[IDX_W].idx[0];
    assign best_val = g_lvl[IDX_W].val[0];

endmodule

// File: rtl/survivor_register_exchange.sv
// survivor_register_exchange
// Register-exchange survivor-path memory for the Viterbi decoder. Each
// accepted trellis step does three things:
//   - It extends every state's survivor with that state's input bit.
//   - It picks the minimum-metric state.
//   - Once TB_DEPTH steps of the current frame have been seen, it emits
//     the oldest survivor bit of that state as the decoded bit.
//
// Ports:
//   i_clk         in   1                 clock, rising edge
//   i_rst         in   1                 asynchronous active-high reset
//   i_valid       in   1                 a trellis step is present
//   i_start       in   1                 first step of a new frame (qualified by i_valid)
//   i_dec         in   NUM_STATES        ACS decision per state (LSB of chosen predecessor)
//   i_pm          in   NUM_STATES*PM_W   path metric per state after this step
//   o_valid       out  1                 o_bit valid, one-cycle pulse
//   o_bit         out  1                 decoded bit
//   o_best_state  out  SW                argmin state used for o_bit
module survivor_register_exchange
    import viterbi_pkg::*;
#(
    parameter  int K          = 3,
    parameter  int PM_W       = 2,
    parameter  int TB_DEPTH   = 16,
    localparam int NUM_STATES = num_states(K),
    localparam int SW         = state_bits(K)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic                       i_start,
    input  logic [NUM_STATES-1:0]      i_dec,
    input  logic [NUM_STATES*PM_W-1:0] i_pm,
    output logic                       o_valid,
    output logic                       o_bit,
    output logic [SW-1:0]              o_best_state
);

    localparam int                FILL_W    = $clog2(TB_DEPTH + 1);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(TB_DEPTH);

    logic [FILL_W-1:0]     fill;
    logic [FILL_W-1:0]     fill_n;
    logic [NUM_STATES-1:0] oldest;
    logic [SW-1:0]         best;
    logic [PM_W-1:0]       best_metric;

    // Per-state survivor storage. Each register keeps only the newest
    // TB_DEPTH-1 bits. The oldest bit of the full TB_DEPTH-bit survivor
    // drops out on the next shift, so it only ever matters as the output
    // candidate. That bit comes straight from the freshly computed
    // survivor instead of being stored.
    for (genvar s = 0; s < NUM_STATES; s++) begin : g_state
        localparam logic [SW-1:0] ST = SW'(s);
        localparam logic [SW-1:0] P0 = SW'(pred_state(s, 1'b0, SW));
        localparam logic [SW-1:0] P1 = SW'(pred_state(s, 1'b1, SW));

        logic [TB_DEPTH-2:0] surv;
        logic [TB_DEPTH-2:0] prev;
        logic [TB_DEPTH-1:0] surv_n;

        // Select the chosen predecessor's history. The first step of a
        // frame starts from an empty history, so the previous frame
        // leaves nothing behind.
        assign prev   = i_start ? '0 : (i_dec[s] ? g_state[P1].surv : g_state[P0].surv);
        assign surv_n = {prev, ST[SW-1]};
        assign oldest[s] = surv_n[TB_DEPTH-1];

        // Survivors advance only on accepted steps. All states read the
        // old values of their predecessors, so the exchange is simultaneous.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                surv <= '0;
            end else if (i_valid) begin
                surv <= surv_n[TB_DEPTH-2:0];
            end
        end
    end

    min_metric_select #(
        .NUM_STATES(NUM_STATES),
        .PM_W      (PM_W)
    ) u_min_select (
        .pm      (i_pm),
        .best_idx(best),
        .best_val(best_metric)
    );

    // Next fill count. It restarts at 1 on a frame start (that step is the
    // frame's first) and otherwise counts up, saturating at TB_DEPTH.
    always_comb begin
        fill_n = fill;
        if (i_start) begin
            fill_n = FILL_ONE;
        end else if (fill != FILL_FULL) begin
            fill_n = fill + FILL_ONE;
        end
    end

    // Fill counter and output registers. o_valid is a single-cycle pulse
    // per accepted step once the pipeline is full. o_bit and o_best_state
    // hold their values through idle cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            fill         <= '0;
            o_valid      <= 1'b0;
            o_bit        <= 1'b0;
            o_best_state <= '0;
        end else begin
            o_valid <= 1'b0;
            if (i_valid) begin
                fill         <= fill_n;
                o_valid      <= (fill_n == FILL_FULL);
                o_bit        <= oldest[best];
                o_best_state <= best;
            end
        end
    end

endmodule

// File: tb/tb_survivor_register_exchange.sv
// tb_survivor_register_exchange
// Self-checking bench for survivor_register_exchange with K=3, PM_W=2 and
// TB_DEPTH=16. The bench has two parts:
//   - A stimulus table covers the all-zero stream, the argmin tie-break
//     and the idle hold.
//   - Hand-written streaming sequences cover ideal decoding, i_valid gaps,
//     a mid-frame i_start and an asynchronous reset during streaming.
module tb_survivor_register_exchange;

    localparam int TBD = 16;

    localparam logic [39:0] PAT_A = 40'b1011001110_0101110010_1100011101_0011011000;
    localparam logic [39:0] PAT_B = 40'b0110100111_1000110101_0011100101_1101001011;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic       i_start;
    logic [3:0] i_dec;
    logic [7:0] i_pm;
    logic       o_valid;
    logic       o_bit;
    logic [1:0] o_best_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       valid;
        logic       start;
        logic [3:0] dec;
        logic [7:0] pm;
        logic       exp_valid;
        logic       exp_bit;
        logic [1:0] exp_best;
    } vec_t;

    vec_t vecs[$];

    survivor_register_exchange #(
        .K       (3),
        .PM_W    (2),
        .TB_DEPTH(TBD)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .i_start     (i_start),
        .i_dec       (i_dec),
        .i_pm        (i_pm),
        .o_valid     (o_valid),
        .o_bit       (o_bit),
        .o_best_state(o_best_state)
    );

    always #5 i_clk = ~i_clk;

    // Drive one cycle of inputs, then land 1 ns after the rising edge so
    // that the registered outputs of this step can be sampled.
    task automatic applyStimulus(input logic valid, input logic start,
                                 input logic [3:0] dec, input logic [7:0] pm);
        i_valid = valid;
        i_start = start;
        i_dec   = dec;
        i_pm    = pm;
        @(posedge i_clk);
        #1;
    endtask

    // Compare all three outputs against the expected values.
    task automatic checkOutput(input string name, input logic ev, input logic eb,
                               input logic [1:0] es);
        checks++;
        if (o_valid !== ev) begin
            failures++;
            $display("[TB] FAIL %s o_valid: got %b, want %b", name, o_valid, ev);
        end
        checks++;
        if (o_bit !== eb) begin
            failures++;
            $display("[TB] FAIL %s o_bit: got %b, want %b", name, o_bit, eb);
        end
        checks++;
        if (o_best_state !== es) begin
            failures++;
            $display("[TB] FAIL %s o_best_state: got %0d, want %0d", name, o_best_state, es);
        end
    endtask

    // Feed pattern bits as ideal (noise-free) decisions. The encoder state
    // is {u_t, u_t-1}. The true next state gets the LSB of its true
    // predecessor as its decision and a metric of 0; every other state
    // gets a metric of 3. Before the pipeline fills, o_bit must be 0,
    // because history starts empty. After that, o_bit must equal the
    // input from TBD-1 steps earlier. Idle cycles in between present junk
    // with i_start high, and the outputs must hold.
    task automatic streamFrame(input string name, input logic [39:0] pat, input int nsteps,
                               input int gap, input logic use_start);
        logic [1:0] enc;
        logic [1:0] s_new;
        logic [3:0] dec;
        logic [7:0] pm;
        logic       u;
        logic       ev;
        logic       eb;
        enc = 2'b00;
        for (int n = 0; n < nsteps; n++) begin
            u     = pat[39-n];
            s_new = {u, enc[1]};
            dec   = 4'b0000;
            dec[s_new] = enc[0];
            pm    = 8'hFF;
            pm[s_new*2 +: 2] = 2'b00;
            applyStimulus(1'b1, use_start && (n == 0), dec, pm);
            ev = (n >= TBD - 1);
            eb = ev ? pat[39-(n-TBD+1)] : 1'b0;
            checkOutput($sformatf("%s step %0d", name, n), ev, eb, s_new);
            enc = s_new;
            for (int g = 0; g < gap; g++) begin
                applyStimulus(1'b0, 1'b1, ~dec, ~pm);
                checkOutput($sformatf("%s idle %0d.%0d", name, n, g), 1'b0, eb, s_new);
            end
        end
    endtask

    initial begin
        vec_t v;

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_start = 1'b0;
        i_dec   = 4'b0000;
        i_pm    = 8'h00;
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("reset", 1'b0, 1'b0, 2'd0);
        #3 i_rst = 1'b0;

        // All-zero stream: state 0 has the lowest metric. Outputs appear
        // from step 15 onward and are all zero.
        for (int n = 0; n < 20; n++) begin
            v = '{valid: 1'b1, start: (n == 0), dec: 4'b0000, pm: 8'hFC,
                  exp_valid: (n >= TBD - 1), exp_bit: 1'b0, exp_best: 2'd0};
            vecs.push_back(v);
        end
        // Tie-break cases. With every decision 0, the oldest bit of every
        // survivor is still 0.
        v = '{1'b1, 1'b0, 4'b0000, 8'hAA, 1'b1, 1'b0, 2'd0}; vecs.push_back(v); // all metrics 2
        v = '{1'b1, 1'b0, 4'b0000, 8'h5A, 1'b1, 1'b0, 2'd2}; vecs.push_back(v); // pm2=pm3=1
        v = '{1'b1, 1'b0, 4'b0000, 8'h33, 1'b1, 1'b0, 2'd1}; vecs.push_back(v); // pm1=pm3=0
        v = '{1'b1, 1'b0, 4'b0000, 8'hBF, 1'b1, 1'b0, 2'd3}; vecs.push_back(v); // only pm3 lower
        // Idle cycle: o_valid drops, and o_bit/o_best_state hold.
        v = '{1'b0, 1'b1, 4'b1111, 8'h00, 1'b0, 1'b0, 2'd3}; vecs.push_back(v);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].valid, vecs[i].start, vecs[i].dec, vecs[i].pm);
            checkOutput($sformatf("vec %0d", i), vecs[i].exp_valid, vecs[i].exp_bit,
                        vecs[i].exp_best);
        end

        streamFrame("ideal", PAT_A, 40, 0, 1'b1);
        streamFrame("gaps", PAT_A, 40, 3, 1'b1);

        // Restarting a frame at step 30 discards the old history.
        streamFrame("frame_a", PAT_A, 30, 0, 1'b1);
        streamFrame("frame_b", PAT_B, 25, 0, 1'b1);

        // Reset pulse between clock edges clears the outputs immediately.
        // The next stream (without i_start) must match a fresh run.
        streamFrame("pre_reset", PAT_B, 20, 0, 1'b1);
        i_valid = 1'b0;
        #2 i_rst = 1'b1;
        #1 checkOutput("async reset", 1'b0, 1'b0, 2'd0);
        #2 i_rst = 1'b0;
        streamFrame("post_reset", PAT_A, 40, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
